multicycle_control_fsm: RTL

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

---
 rtl/multicycle_control_fsm_pkg.sv | 33 +++
 rtl/multicycle_control_fsm.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared opcode, state and mux-select constants for the multicycle control FSM.
package multicycle_control_fsm_pkg;

   localparam logic [6:0] OP_ARITHMETIC     = 7'b0110011;
   localparam logic [6:0] OP_ARITHMETIC_IMM = 7'b0010011;
   localparam logic [6:0] OP_LOAD           = 7'b0000011;
   localparam logic [6:0] OP_STORE          = 7'b0100011;
   localparam logic [6:0] OP_BRANCH         = 7'b1100011;
   localparam logic [6:0] OP_JAL            = 7'b1101111;
   localparam logic [6:0] OP_JALR           = 7'b1100111;
   localparam logic [6:0] OP_ECALL          = 7'b1110011;

   typedef enum logic [2:0] {
      StIf   = 3'd0,
      StId   = 3'd1,
      StEx   = 3'd2,
      StMem  = 3'd3,
      StWb   = 3'd4,
      StHalt = 3'd5
   } state_e;

   localparam logic [1:0] PC_SRC_PC4    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_ALU    = 2'b10;

   localparam logic [1:0] WB_ALUOUT = 2'b00;
   localparam logic [1:0] WB_MDR    = 2'b01;
   localparam logic [1:0] WB_PC4    = 2'b10;

   localparam logic [1:0] ALU_CTRL_ADD    = 2'b00;
   localparam logic [1:0] ALU_CTRL_DECODE = 2'b01;

endpackage

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32 control unit: IF/ID/EX/MEM/WB sequencing, halt on ECALL,
// and a retired-instruction counter that ticks on every PC write.
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
#(
   parameter int unsigned RET_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic             mem_ready,
   input  logic             bcond,
   input  logic             halt_req,
   output logic             pc_write,
   output logic             ir_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             i_or_d,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic             alu_src_b,
   output logic [1:0]       pc_source,
   output logic [1:0]       wb_sel,
   output logic [1:0]       alu_ctrl_sel,
   output logic [2:0]       state,
   output logic             is_halted,
   output logic             retire_pulse,
   output logic [RET_W-1:0] retired_cnt
);

   state_e           state_q, state_d;
   logic [RET_W-1:0] retired_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIf;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         if (pc_write) retired_q <= retired_q + RET_W'(1);
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_write     = 1'b0;
      ir_write     = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      i_or_d       = 1'b0;
      reg_write    = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = 1'b0;
      pc_source    = PC_SRC_PC4;
      wb_sel       = WB_ALUOUT;
      alu_ctrl_sel = ALU_CTRL_ADD;
      is_halted    = 1'b0;

      case (state_q)
         StIf: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               state_d  = StId;
            end
         end
         StId: begin
            // Speculative branch target: ALUOut <- PC + imm.
            alu_src_b = 1'b1;
            state_d   = (opcode == OP_ECALL && halt_req) ? StHalt : StEx;
         end
         StEx: begin
            state_d = StIf;
            case (opcode)
               OP_ARITHMETIC: begin
                  alu_src_a    = 1'b1;
                  alu_ctrl_sel = ALU_CTRL_DECODE;
                  state_d      = StWb;
               end
               OP_ARITHMETIC_IMM: begin
                  alu_src_a    = 1'b1;
                  alu_src_b    = 1'b1;
                  alu_ctrl_sel = ALU_CTRL_DECODE;
                  state_d      = StWb;
               end
               OP_LOAD, OP_STORE: begin
                  alu_src_a = 1'b1;
                  alu_src_b = 1'b1;
                  state_d   = StMem;
               end
               OP_BRANCH: begin
                  alu_src_a    = 1'b1;
                  alu_ctrl_sel = ALU_CTRL_DECODE;
                  pc_write     = 1'b1;
                  pc_source    = bcond ? PC_SRC_ALUOUT : PC_SRC_PC4;
               end
               OP_JAL: begin
                  reg_write = 1'b1;
                  wb_sel    = WB_PC4;
                  pc_write  = 1'b1;
                  pc_source = PC_SRC_ALUOUT;
               end
               OP_JALR: begin
                  alu_src_a = 1'b1;
                  alu_src_b = 1'b1;
                  reg_write = 1'b1;
                  wb_sel    = WB_PC4;
                  pc_write  = 1'b1;
                  pc_source = PC_SRC_ALU;
               end
               default: pc_write = 1'b1;  // ECALL without halt and unknown opcodes act as NOP
            endcase
         end
         StMem: begin
            i_or_d = 1'b1;
            if (opcode == OP_LOAD) begin
               mem_read = 1'b1;
               if (mem_ready) state_d = StWb;
            end else begin
               mem_write = 1'b1;
               if (mem_ready) begin
                  pc_write = 1'b1;
                  state_d  = StIf;
               end
            end
         end
         StWb: begin
            reg_write = 1'b1;
            wb_sel    = (opcode == OP_LOAD) ? WB_MDR : WB_ALUOUT;
            pc_write  = 1'b1;
            state_d   = StIf;
         end
         StHalt: is_halted = 1'b1;
         default: state_d = StIf;
      endcase

      if (reset) begin
         pc_write     = 1'b0;
         ir_write     = 1'b0;
         mem_read     = 1'b0;
         mem_write    = 1'b0;
         i_or_d       = 1'b0;
         reg_write    = 1'b0;
         alu_src_a    = 1'b0;
         alu_src_b    = 1'b0;
         pc_source    = PC_SRC_PC4;
         wb_sel       = WB_ALUOUT;
         alu_ctrl_sel = ALU_CTRL_ADD;
         is_halted    = 1'b0;
      end
   end

   assign retire_pulse = pc_write;
   assign state        = state_q;
   assign retired_cnt  = retired_q;

endmodule
